// File: rtl/ccd_sobel_stage.sv
// Pixel pre-processor between CCD capture and the SRAM input FIFO: bypass, greyscale,
// Sobel magnitude or thresholded Sobel, with border zeroing and a sticky FIFO overflow flag.
module ccd_sobel_stage #(
   parameter int         WIDTH  = 800,
   parameter int         HEIGHT = 480,
   parameter logic [9:0] THRESH = 10'd512
) (
   input  logic        CCD_FIFO_WRCLK,
   input  logic        RESET_N,
   input  logic        iDVAL,
   input  logic        iSOF,
   input  logic [29:0] iDATA,
   input  logic [1:0]  iMODE,
   input  logic        iFIFO_FULL,
   output logic        oDVAL,
   output logic [29:0] oDATA,
   output logic        oOVERFLOW
);

   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
   localparam logic [RW-1:0] ROW_CLOAD = RW'(HEIGHT - 2);
   localparam logic [1:0] MODE_BYP   = 2'b00;
   localparam logic [1:0] MODE_GREY  = 2'b01;
   localparam logic [1:0] MODE_SOBEL = 2'b10;
   localparam logic [1:0] MODE_THR   = 2'b11;

   logic              acc, sof_acc;
   logic [11:0]       rgb_sum;
   logic [9:0]        grey;
   logic [1:0]        mode_cur;
   logic [CW-1:0]     col_cur, ccol_cur;
   logic [RW-1:0]     row_cur, crow_cur;
   logic              border_cur;
   logic [9:0]        tap1, tap2;

   logic [1:0]        mode_q, mode_d;
   logic [CW-1:0]     col_q, col_d, ccol_q, ccol_d, ptr_q, ptr_d;
   logic [RW-1:0]     row_q, row_d, crow_q, crow_d;
   logic              pos_vld_q, pos_vld_d;
   logic [2:0][2:0][9:0] w_q, w_d;
   logic              v1_q, v1_d, border1_q, border1_d;
   logic [1:0]        mode1_q, mode1_d;
   logic [29:0]       byp1_q, byp1_d;
   logic              v2_q, v2_d;
   logic [29:0]       data2_q, data2_d;
   logic              odval_q, odval_d;
   logic [29:0]       odata_q, odata_d;
   logic              ovf_q, ovf_d;

   logic [9:0]        lb1_q [WIDTH];
   logic [9:0]        lb2_q [WIDTH];

   logic signed [12:0] gx, gy;
   logic [12:0]       ax, ay;
   logic [13:0]       mag;
   logic [9:0]        sob_v, thr_v;

   function automatic logic signed [12:0] sx(input logic [9:0] v);
      return signed'({3'b000, v});
   endfunction

   assign acc      = iDVAL;
   assign sof_acc  = iDVAL & iSOF;
   assign mode_cur = sof_acc ? iMODE : mode_q;
   assign tap1     = lb1_q[ptr_q];
   assign tap2     = lb2_q[ptr_q];

   // Y = (R+G+B)*683 >> 11, a truncating divide-by-three
   always_comb begin
      rgb_sum = {2'b00, iDATA[29:20]} + {2'b00, iDATA[19:10]} + {2'b00, iDATA[9:0]};
      grey    = 10'(({9'b0, rgb_sum} * 21'd683) >> 11);
   end

   // An accepted SOF overrides the stored position of the pixel presented with it
   always_comb begin
      col_cur    = sof_acc ? '0 : col_q;
      row_cur    = sof_acc ? '0 : row_q;
      ccol_cur   = sof_acc ? COL_LAST : ccol_q;
      crow_cur   = sof_acc ? ROW_CLOAD : crow_q;
      pos_vld_d  = pos_vld_q | sof_acc;
      border_cur = !pos_vld_d || (crow_cur == '0) || (crow_cur == ROW_LAST) ||
                   (ccol_cur == '0) || (ccol_cur == COL_LAST);
   end

   always_comb begin
      mode_d = mode_q;
      col_d  = col_q;
      row_d  = row_q;
      ccol_d = ccol_q;
      crow_d = crow_q;
      ptr_d  = ptr_q;
      if (acc) begin
         mode_d = mode_cur;
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
         if (ccol_cur == COL_LAST) begin
            ccol_d = '0;
            crow_d = (crow_cur == ROW_LAST) ? '0 : crow_cur + 1'b1;
         end else begin
            ccol_d = ccol_cur + 1'b1;
            crow_d = crow_cur;
         end
         ptr_d = (ptr_q == COL_LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   // Window rows: 0 = oldest line, 2 = newest; columns: 2 = newest pixel
   always_comb begin
      w_d       = w_q;
      mode1_d   = mode1_q;
      border1_d = border1_q;
      byp1_d    = byp1_q;
      v1_d      = acc;
      if (acc) begin
         for (int r = 0; r < 3; r++) begin
            w_d[r][0] = w_q[r][1];
            w_d[r][1] = w_q[r][2];
         end
         w_d[0][2] = tap2;
         w_d[1][2] = tap1;
         w_d[2][2] = grey;
         mode1_d   = mode_cur;
         border1_d = border_cur;
         byp1_d    = iDATA;
      end
   end

   always_comb begin
      gx = (sx(w_q[0][2]) + (sx(w_q[1][2]) <<< 1) + sx(w_q[2][2])) -
           (sx(w_q[0][0]) + (sx(w_q[1][0]) <<< 1) + sx(w_q[2][0]));
      gy = (sx(w_q[0][0]) + (sx(w_q[0][1]) <<< 1) + sx(w_q[0][2])) -
           (sx(w_q[2][0]) + (sx(w_q[2][1]) <<< 1) + sx(w_q[2][2]));
      ax    = gx[12] ? $unsigned(-gx) : $unsigned(gx);
      ay    = gy[12] ? $unsigned(-gy) : $unsigned(gy);
      mag   = {1'b0, ax} + {1'b0, ay};
      sob_v = border1_q ? 10'd0 : ((mag > 14'd1023) ? 10'h3FF : mag[9:0]);
      thr_v = (!border1_q && (mag >= {4'b0000, THRESH})) ? 10'h3FF : 10'd0;
   end

   always_comb begin
      v2_d    = v1_q;
      data2_d = data2_q;
      if (v1_q) begin
         case (mode1_q)
            MODE_BYP:   data2_d = byp1_q;
            MODE_GREY:  data2_d = {w_q[2][2], w_q[2][2], w_q[2][2]};
            MODE_SOBEL: data2_d = {sob_v, sob_v, sob_v};
            MODE_THR:   data2_d = {thr_v, thr_v, thr_v};
            default:    data2_d = byp1_q;
         endcase
      end
      odval_d = v2_q;
      odata_d = v2_q ? data2_q : odata_q;
      // a set event in the same cycle as an SOF wins over the clear
      ovf_d   = (sof_acc ? 1'b0 : ovf_q) | (odval_q & iFIFO_FULL);
   end

   always_ff @(posedge CCD_FIFO_WRCLK or negedge RESET_N) begin
      if (!RESET_N) begin
         mode_q    <= MODE_BYP;
         col_q     <= '0;
         row_q     <= '0;
         ccol_q    <= COL_LAST;
         crow_q    <= ROW_CLOAD;
         pos_vld_q <= 1'b0;
         ptr_q     <= '0;
         w_q       <= '0;
         v1_q      <= 1'b0;
         mode1_q   <= MODE_BYP;
         border1_q <= 1'b1;
         byp1_q    <= '0;
         v2_q      <= 1'b0;
         data2_q   <= '0;
         odval_q   <= 1'b0;
         odata_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         col_q     <= col_d;
         row_q     <= row_d;
         ccol_q    <= ccol_d;
         crow_q    <= crow_d;
         pos_vld_q <= pos_vld_d;
         ptr_q     <= ptr_d;
         w_q       <= w_d;
         v1_q      <= v1_d;
         mode1_q   <= mode1_d;
         border1_q <= border1_d;
         byp1_q    <= byp1_d;
         v2_q      <= v2_d;
         data2_q   <= data2_d;
         odval_q   <= odval_d;
         odata_q   <= odata_d;
         ovf_q     <= ovf_d;
      end
   end

   // Line buffer storage carries no reset; border zeroing hides stale contents
   always_ff @(posedge CCD_FIFO_WRCLK) begin
      if (acc) begin
         lb1_q[ptr_q] <= grey;
         lb2_q[ptr_q] <= tap1;
      end
   end

   assign oDVAL     = odval_q;
   assign oDATA     = odata_q;
   assign oOVERFLOW = ovf_q;

endmodule

// File: tb/tb_ccd_sobel_stage.sv
// Randomised and directed bench for ccd_sobel_stage, scored against a raster-history model
// of the pixel stream (small 8x6 frame geometry).
module tb_ccd_sobel_stage;

   localparam int W = 8;
   localparam int H = 6;
   localparam int N = W * H;
   localparam logic [9:0] TH = 10'd512;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dval = 1'b0, sof = 1'b0, full = 1'b0;
   logic [29:0] data = '0;
   logic [1:0]  mode = '0;
   logic        odval, ovf;
   logic [29:0] odata;

   ccd_sobel_stage #(.WIDTH(W), .HEIGHT(H), .THRESH(TH)) dut (
      .CCD_FIFO_WRCLK(clk),
      .RESET_N(rst_n),
      .iDVAL(dval),
      .iSOF(sof),
      .iDATA(data),
      .iMODE(mode),
      .iFIFO_FULL(full),
      .oDVAL(odval),
      .oDATA(odata),
      .oOVERFLOW(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0] d;
      int          r;
      int          c;
      int          tag;
   } exp_t;

   exp_t        expq[$];
   bit          dvq[$];
   int          hist[$];
   bit          ovf_m = 1'b0;
   bit          posv = 1'b0;
   logic [1:0]  mode_m = 2'b00;
   int          idx = 0;
   int          tag_now = 0;
   int          n_vec = 0, n_err = 0;
   int          tag_cnt = 0, tag_nz = 0;
   int          dut_frame [H][W];

   task automatic chk(input string name, input longint act, input longint expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int grey_of(input logic [29:0] p);
      int s;
      s = int'(p[29:20]) + int'(p[19:10]) + int'(p[9:0]);
      return (s * 683) / 2048;
   endfunction

   // Y of the pixel at (dr,dc) from the window centre, centre lagging newest by W+1
   function automatic int pix(input int k, input int dr, input int dc);
      return hist[k - (W + 1) + dr * W + dc];
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Model step for the coming rising edge, using the inputs just driven
   task automatic apply();
      exp_t e;
      bit cur_dv;
      int y, k, cl, cr, cc, gx, gy, mag, v;
      bit bord;
      logic [9:0] v10;
      if (!rst_n) begin
         dvq.delete();
         expq.delete();
         hist.delete();
         ovf_m = 1'b0;
         posv = 1'b0;
         mode_m = 2'b00;
         idx = 0;
         return;
      end
      cur_dv = (dvq.size() == 3) ? dvq[0] : 1'b0;
      ovf_m = ((dval && sof) ? 1'b0 : ovf_m) | (cur_dv & full);
      dvq.push_back(dval);
      if (dvq.size() > 3) void'(dvq.pop_front());
      if (dval) begin
         if (sof) begin
            mode_m = mode;
            idx = 0;
            posv = 1'b1;
         end
         y = grey_of(data);
         hist.push_back(y);
         k = hist.size() - 1;
         cl = (idx - (W + 1) + N) % N;
         cr = cl / W;
         cc = cl % W;
         bord = !posv || cr == 0 || cr == H - 1 || cc == 0 || cc == W - 1;
         e.r = posv ? cr : -1;
         e.c = cc;
         e.tag = tag_now;
         v = 0;
         if (!bord) begin
            gx = (pix(k,-1,1) - pix(k,-1,-1)) + 2 * (pix(k,0,1) - pix(k,0,-1)) + (pix(k,1,1) - pix(k,1,-1));
            gy = (pix(k,-1,-1) - pix(k,1,-1)) + 2 * (pix(k,-1,0) - pix(k,1,0)) + (pix(k,-1,1) - pix(k,1,1));
            mag = iabs(gx) + iabs(gy);
            v = (mode_m == 2'b10) ? ((mag > 1023) ? 1023 : mag) : ((mag >= int'(TH)) ? 1023 : 0);
         end
         case (mode_m)
            2'b00:   e.d = data;
            2'b01:   begin v10 = 10'(y); e.d = {v10, v10, v10}; end
            default: begin v10 = 10'(v); e.d = {v10, v10, v10}; end
         endcase
         expq.push_back(e);
         idx = (idx + 1) % N;
      end
   endtask

   task automatic step(input bit r, input bit v, input bit s, input logic [29:0] d,
                       input logic [1:0] m, input bit f);
      @(negedge clk);
      #1;
      rst_n = r; dval = v; sof = s; data = d; mode = m; full = f;
      apply();
   endtask

   // Compare process: every cycle, away from the rising edge
   always @(negedge clk) begin
      exp_t e;
      bit edv;
      edv = (dvq.size() == 3) ? dvq[0] : 1'b0;
      chk("odval", odval, edv);
      chk("overflow", ovf, ovf_m);
      if (!rst_n) chk("reset_odata", odata, 0);
      if (odval && edv) begin
         if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL expq: output with no expected pixel at %0t", $time);
         end else begin
            e = expq.pop_front();
            chk("odata", odata, e.d);
            if (e.r >= 0) dut_frame[e.r][e.c] = int'(odata[9:0]);
            if (e.tag != 0) begin
               tag_cnt++;
               if (odata != 0) tag_nz++;
            end
         end
      end
   end

   function automatic logic [29:0] img(input int kind, input int r, input int c);
      case (kind)
         0:       return (c < 4) ? 30'd0 : 30'h3FFF_FFFF;
         1:       return (r < 3) ? 30'd0 : {10'd300, 20'd0};
         default: return (r < 3) ? 30'd0 : {10'd600, 20'd0};
      endcase
   endfunction

   task automatic run_frame(input int kind, input logic [1:0] m);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            dut_frame[r][c] = -1;
      for (int i = 0; i < N; i++)
         step(1, 1, (i == 0), img(kind, i / W, i % W), m, 0);
      repeat (3) step(1, 0, 0, '0, m, 0);
   endtask

   initial begin
      bit rv, rs, rf;
      // reset held with valid input
      repeat (5) step(0, 1, 0, 30'($urandom), 2'b00, 0);
      // bypass: latency exactly three cycles
      step(1, 1, 1, 30'h3FF00155, 2'b00, 0);
      step(1, 0, 0, '0, 2'b00, 0);
      step(1, 0, 0, '0, 2'b00, 0);
      chk("latency_not_early", odval, 0);
      step(1, 0, 0, '0, 2'b00, 0);
      chk("first_dval", odval, 1);
      chk("bypass_lit", odata, 30'h3FF00155);
      // greyscale
      step(1, 1, 1, {10'd300, 20'd0}, 2'b01, 0);
      step(1, 1, 0, 30'h3FFF_FFFF, 2'b10, 0);
      step(1, 0, 0, '0, 2'b10, 0);
      step(1, 0, 0, '0, 2'b10, 0);
      chk("grey_100", odata, {10'd100, 10'd100, 10'd100});
      step(1, 0, 0, '0, 2'b10, 0);
      chk("grey_1023", odata, 30'h3FFF_FFFF);
      // Sobel on a vertical edge
      run_frame(0, 2'b10);
      for (int r = 1; r <= 4; r++) begin
         chk("sobel_col2", dut_frame[r][2], 0);
         chk("sobel_col3", dut_frame[r][3], 1023);
         chk("sobel_col4", dut_frame[r][4], 1023);
      end
      chk("border_row0", dut_frame[0][4], 0);
      chk("border_col0", dut_frame[3][0], 0);
      chk("border_collast", dut_frame[3][7], 0);
      // threshold on horizontal edges
      run_frame(1, 2'b11);
      chk("thr_step100_r2", dut_frame[2][3], 0);
      chk("thr_step100_r3", dut_frame[3][3], 0);
      run_frame(2, 2'b11);
      chk("thr_step200_r2", dut_frame[2][3], 1023);
      chk("thr_step200_r3", dut_frame[3][4], 1023);
      // overflow and mid-line SOF resync
      step(1, 1, 1, 30'($urandom), 2'b10, 0);
      for (int i = 1; i <= 10; i++) step(1, 1, 0, 30'($urandom), 2'b10, (i == 6));
      chk("ovf_set", ovf, 1);
      tag_now = 1;
      step(1, 1, 1, 30'($urandom), 2'b10, 0);
      for (int i = 1; i <= W; i++) begin
         step(1, 1, 0, 30'($urandom), 2'b01, 0);
         if (i == 1) chk("ovf_clr_sof", ovf, 0);
      end
      tag_now = 0;
      repeat (3) step(1, 0, 0, '0, 2'b00, 0);
      chk("resync_count", tag_cnt, W + 1);
      chk("resync_zero", tag_nz, 0);
      // randomised frames with idles, mode noise, FIFO-full, stray SOF, one reset
      for (int rd = 0; rd < 8; rd++) begin
         step(1, 1, 1, 30'($urandom), 2'($urandom_range(0, 3)), 0);
         for (int i = 0; i < 90; i++) begin
            if (rd == 4 && (i == 40 || i == 41)) begin
               step(0, 1, 0, 30'($urandom), 2'b10, 0);
               continue;
            end
            rv = ($urandom_range(0, 3) != 0);
            rs = rv && ($urandom_range(0, 79) == 0);
            rf = ($urandom_range(0, 9) == 0);
            step(1, rv, rs, 30'($urandom), 2'($urandom_range(0, 3)), rf);
         end
      end
      repeat (4) step(1, 0, 0, '0, 2'b00, 0);
      chk("queue_drained", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
